// File: rtl/handshake_constant_check.sv
// -----------------------------------------------------------------------------
// handshake_constant_check
//
// Consumes a valid/ready token stream and compares every accepted token
// against a fixed constant. It counts accepted tokens and mismatches, and it
// remembers the first bad token. It can stop accepting after the first
// mismatch, or after a fixed number of tokens.
//
// Parameters
//   DATA_WIDTH  : width of the data token
//   EXPECTED    : reference constant; the low DATA_WIDTH bits are used
//   CNT_WIDTH   : width of tok_count / err_count
//   N_TOKENS    : tokens to accept before entering DONE (0 = unlimited)
//   HALT_ON_ERR : 1 = stop accepting on the first mismatching token
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   synchronous restart (zero counters, back to RUN)
//   ins        in   [DATA_WIDTH]  incoming data token
//   ins_valid  in   token present on ins
//   ins_ready  out  checker accepts a token this cycle
//   tok_count  out  [CNT_WIDTH]   tokens accepted (saturating)
//   err_count  out  [CNT_WIDTH]   accepted tokens that mismatched (saturating)
//   err_flag   out  sticky, set on the first mismatch
//   first_bad  out  [DATA_WIDTH]  data of the first mismatching token
//   done       out  high while in DONE
//
// Optional feature
//   HANDSHAKE_CONSTANT_CHECK_THROTTLE_EN : when defined, a toggle register
//   throttles ins_ready to every other cycle while running.
// -----------------------------------------------------------------------------
module handshake_constant_check #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] EXPECTED    = 32'h04AA001B,
  parameter int          CNT_WIDTH   = 16,
  parameter int          N_TOKENS    = 0,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [CNT_WIDTH-1:0]  tok_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_bad,
  output logic                  done
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] EXP_VAL = DATA_WIDTH'(EXPECTED);

  // The token limit only matters if the saturating counter can reach it.
  localparam bit N_TOK_ACTIVE =
    (N_TOKENS > 0) && ((CNT_WIDTH >= 31) || (N_TOKENS < (1 << CNT_WIDTH)));

  // Count value held just before the limiting transfer.
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_TOKENS - 1);

  state_t state_q;
  state_t state_d;
  logic   started;
  logic   run_ok;
  logic   xfer;
  logic   mismatch;
  logic   done_hit;

  // started holds ins_ready low until the first edge after reset release.
  // Ready therefore depends only on registered state and never on rst directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  assign run_ok = (state_q == RUN) && started;

`ifdef HANDSHAKE_CONSTANT_CHECK_THROTTLE_EN
  logic toggle;

  // The toggle restarts at 0 on clear, so the first ready cycle after a
  // restart is always the second one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle <= 1'b0;
    end else if (clear) begin
      toggle <= 1'b0;
    end else if (state_q == RUN) begin
      toggle <= ~toggle;
    end
  end

  assign ins_ready = run_ok & toggle;
`else
  assign ins_ready = run_ok;
`endif

  // clear wins over a simultaneous handshake: that token is neither counted
  // nor checked.
  assign xfer     = ins_valid && ins_ready && !clear;
  assign mismatch = (ins != EXP_VAL);
  assign done_hit = N_TOK_ACTIVE && (tok_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Reaching the token limit takes precedence over halting on a mismatch.
  // The error is still recorded by the counter block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (xfer) begin
          if (done_hit) begin
            state_d = DONE;
          end else if (HALT_ON_ERR && mismatch) begin
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
    if (clear) begin
      state_d = RUN;
    end
  end

  // Both counters saturate at all-ones rather than wrapping. first_bad is
  // captured only while err_flag is still clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
      first_bad <= '0;
    end else if (clear) begin
      tok_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
      first_bad <= '0;
    end else if (xfer) begin
      if (tok_count != '1) begin
        tok_count <= tok_count + 1'b1;
      end
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        if (!err_flag) begin
          err_flag  <= 1'b1;
          first_bad <= ins;
        end
      end
    end
  end

  assign done = (state_q == DONE);

endmodule

// File: tb/tb_handshake_constant_check.sv
// -----------------------------------------------------------------------------
// tb_handshake_constant_check
//
// Drives three handshake_constant_check instances with one shared stimulus:
//   dut_a : default parameters (unlimited tokens, halt on error)
//   dut_b : N_TOKENS = 3, halt on error
//   dut_c : CNT_WIDTH = 2, HALT_ON_ERR = 0
// A behavioural model per instance predicts every output. The outputs are
// compared on every falling clock edge. Directed scenarios add literal
// expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_handshake_constant_check;

`ifdef HANDSHAKE_CONSTANT_CHECK_THROTTLE_EN
  localparam bit THROTTLE = 1'b1;
`else
  localparam bit THROTTLE = 1'b0;
`endif

  localparam logic [31:0] GOOD = 32'h04AA001B;
  localparam logic [31:0] DEAD = 32'h0000DEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        ins_valid;
  logic [31:0] ins;

  logic        rdy_a, flag_a, done_a;
  logic [15:0] tok_a, err_a;
  logic [31:0] fb_a;
  logic        rdy_b, flag_b, done_b;
  logic [15:0] tok_b, err_b;
  logic [31:0] fb_b;
  logic        rdy_c, flag_c, done_c;
  logic [1:0]  tok_c, err_c;
  logic [31:0] fb_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  handshake_constant_check dut_a (
    .clk(clk), .rst(rst), .clear(clear), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(rdy_a), .tok_count(tok_a), .err_count(err_a),
    .err_flag(flag_a), .first_bad(fb_a), .done(done_a)
  );

  handshake_constant_check #(.N_TOKENS(3)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(rdy_b), .tok_count(tok_b), .err_count(err_b),
    .err_flag(flag_b), .first_bad(fb_b), .done(done_b)
  );

  handshake_constant_check #(.CNT_WIDTH(2), .HALT_ON_ERR(1'b0)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(rdy_c), .tok_count(tok_c), .err_count(err_c),
    .err_flag(flag_c), .first_bad(fb_c), .done(done_c)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: what a checker with these parameters must show.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          started;
    bit          halted;
    bit          finished;
    bit          flag;
    bit          phase;
    int unsigned tok;
    int unsigned err;
    logic [31:0] first;
  } model_t;

  model_t mdl [3];

  function automatic int unsigned limit_of(int i);
    return (i == 1) ? 32'd3 : 32'd0;
  endfunction

  function automatic bit halts_of(int i);
    return (i != 2);
  endfunction

  function automatic int unsigned cmax_of(int i);
    return (i == 2) ? 32'd3 : 32'd65535;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.started  = 1'b0;
    m.halted   = 1'b0;
    m.finished = 1'b0;
    m.flag     = 1'b0;
    m.phase    = 1'b0;
    m.tok      = 0;
    m.err      = 0;
    m.first    = '0;
    return m;
  endfunction

  function automatic bit exp_ready(model_t m);
    return m.started && !m.halted && !m.finished && (!THROTTLE || m.phase);
  endfunction

  function automatic model_t model_next(model_t m, int i, logic clr,
                                        logic v, logic [31:0] d);
    model_t n;
    bit     acc;
    bit     bad;
    n   = m;
    acc = exp_ready(m) && v;
    bad = (d != GOOD);
    if (clr) begin
      n = model_reset();
      n.started = 1'b1;
      return n;
    end
    n.started = 1'b1;
    if (!m.halted && !m.finished) n.phase = !m.phase;
    if (acc) begin
      if (m.tok < cmax_of(i)) n.tok = m.tok + 1;
      if (bad) begin
        if (m.err < cmax_of(i)) n.err = m.err + 1;
        if (!m.flag) begin
          n.flag  = 1'b1;
          n.first = d;
        end
      end
      if (limit_of(i) != 0 && n.tok == limit_of(i)) n.finished = 1'b1;
      else if (bad && halts_of(i)) n.halted = 1'b1;
    end
    return n;
  endfunction

  // Keep the model in step with the DUT: async reset, otherwise one step per edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl[0] <= model_reset();
      mdl[1] <= model_reset();
      mdl[2] <= model_reset();
    end else begin
      mdl[0] <= model_next(mdl[0], 0, clear, ins_valid, ins);
      mdl[1] <= model_next(mdl[1], 1, clear, ins_valid, ins);
      mdl[2] <= model_next(mdl[2], 2, clear, ins_valid, ins);
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInst(input string tag, input model_t m, input logic r,
                           input logic [31:0] t, input logic [31:0] e,
                           input logic f, input logic [31:0] fb, input logic d);
    checkOutput({tag, ".ins_ready"}, {31'd0, r}, {31'd0, exp_ready(m)});
    checkOutput({tag, ".tok_count"}, t, m.tok);
    checkOutput({tag, ".err_count"}, e, m.err);
    checkOutput({tag, ".err_flag"},  {31'd0, f}, {31'd0, m.flag});
    checkOutput({tag, ".first_bad"}, fb, m.first);
    checkOutput({tag, ".done"},      {31'd0, d}, {31'd0, m.finished});
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    checkInst("a", mdl[0], rdy_a, 32'(tok_a), 32'(err_a), flag_a, fb_a, done_a);
    checkInst("b", mdl[1], rdy_b, 32'(tok_b), 32'(err_b), flag_b, fb_b, done_b);
    checkInst("c", mdl[2], rdy_c, 32'(tok_c), 32'(err_c), flag_c, fb_c, done_c);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic ready_of(int sel);
    if (sel == 0) return rdy_a;
    if (sel == 1) return rdy_b;
    return rdy_c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearPulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offer one token and hold it until the selected instance takes it.
  // After four edges the token is withdrawn, which lets stall scenarios run.
  task automatic applyStimulus(input int sel, input logic [31:0] d);
    logic r;
    ins       = d;
    ins_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = ready_of(sel);
      tick();
      if (r) break;
    end
    ins_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] x;
    clear     = 1'b0;
    ins_valid = 1'b0;
    ins       = '0;
    rst       = 1'b1;
    #1 rst    = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_ready_a", {31'd0, rdy_a}, 32'd0);
    checkOutput("rst_tok_a",   32'(tok_a), 32'd0);
    checkOutput("rst_done_b",  {31'd0, done_b}, 32'd0);
    rst = 1'b1;
    tick();

    // Five good tokens; dut_b stops at three, and dut_c saturates at three.
    clearPulse();
    for (int k = 0; k < 5; k++) applyStimulus(0, GOOD);
    checkOutput("good5_tok_a",  32'(tok_a), 32'd5);
    checkOutput("good5_err_a",  32'(err_a), 32'd0);
    checkOutput("good5_flag_a", {31'd0, flag_a}, 32'd0);
    checkOutput("good5_tok_b",  32'(tok_b), 32'd3);
    checkOutput("good5_done_b", {31'd0, done_b}, 32'd1);
    checkOutput("good5_tok_c",  32'(tok_c), 32'd3);

    // A mismatch halts dut_a, and the third token stalls.
    clearPulse();
    applyStimulus(0, GOOD);
    applyStimulus(0, DEAD);
    applyStimulus(0, GOOD);
    checkOutput("halt_tok_a",   32'(tok_a), 32'd2);
    checkOutput("halt_err_a",   32'(err_a), 32'd1);
    checkOutput("halt_first_a", fb_a, DEAD);
    checkOutput("halt_ready_a", {31'd0, rdy_a}, 32'd0);
    checkOutput("halt_tok_c",   32'(tok_c), 32'd3);
    checkOutput("halt_err_c",   32'(err_c), 32'd1);

    // A clear in HALT with valid high discards that token.
    ins       = DEAD;
    ins_valid = 1'b1;
    clearPulse();
    ins_valid = 1'b0;
    checkOutput("clr_tok_a",   32'(tok_a), 32'd0);
    checkOutput("clr_err_a",   32'(err_a), 32'd0);
    checkOutput("clr_flag_a",  {31'd0, flag_a}, 32'd0);
    checkOutput("clr_ready_a", {31'd0, rdy_a}, THROTTLE ? 32'd0 : 32'd1);

    // Six mismatches into dut_c: the counters saturate, and first_bad sticks.
    for (int k = 0; k < 6; k++) applyStimulus(2, 32'h100 + k);
    checkOutput("sat_err_c",   32'(err_c), 32'd3);
    checkOutput("sat_tok_c",   32'(tok_c), 32'd3);
    checkOutput("sat_flag_c",  {31'd0, flag_c}, 32'd1);
    checkOutput("sat_first_c", fb_c, 32'h100);
    checkOutput("sat_tok_a",   32'(tok_a), 32'd1);

    // Reset mid-burst clears the outputs before any clock edge.
    clearPulse();
    applyStimulus(0, GOOD);
    applyStimulus(0, GOOD);
    ins       = GOOD;
    ins_valid = 1'b1;
    rst       = 1'b0;
    #1;
    checkOutput("arst_tok_a",   32'(tok_a), 32'd0);
    checkOutput("arst_ready_a", {31'd0, rdy_a}, 32'd0);
    checkOutput("arst_flag_c",  {31'd0, flag_c}, 32'd0);
    checkOutput("arst_err_c",   32'(err_c), 32'd0);
    repeat (2) tick();
    ins_valid = 1'b0;
    rst       = 1'b1;
    tick();

    // Valid held for eight cycles: alternate transfers only when throttled.
    clearPulse();
    ins       = GOOD;
    ins_valid = 1'b1;
    repeat (8) tick();
    ins_valid = 1'b0;
    checkOutput("burst8_tok_a", 32'(tok_a), THROTTLE ? 32'd4 : 32'd8);

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      clear     = ($urandom_range(0, 24) == 0);
      ins_valid = ($urandom_range(0, 3) != 0);
      x         = $urandom;
      if (x == GOOD) x = x ^ 32'd1;
      ins       = ($urandom_range(0, 7) == 0) ? x : GOOD;
      rst       = ($urandom_range(0, 149) != 0);
      tick();
    end
    clear     = 1'b0;
    ins_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
